// File: rtl/merge_memory_pkg.sv
// Shared types and helpers for the banked SRAM merger and its tracking pipeline.
package merge_memory_pkg;

    // Widest bank index a tracking stage can carry (up to 256 banks).
    localparam int MAX_BANK_W = 8;

    // Bank-index width: clog2 of the bank count, never narrower than one bit.
    function automatic int bank_idx_w(input int num_banks);
        int w;
        w = $clog2(num_banks);
        if (w < 1) w = 1;
        return w;
    endfunction

    // One slot of the response-tracking pipeline.
    typedef struct packed {
        logic                  vld;
        logic                  rd;
        logic                  oor;
        logic [MAX_BANK_W-1:0] bank;
    } track_stage_t;

endpackage

// File: rtl/merge_memory_track_pipe.sv
// Fixed-depth shift register of tracking stages; aligns response flags with
// the read latency of a wrapped memory macro. No stall: shifts every edge.
module merge_memory_track_pipe
    import merge_memory_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  track_stage_t stage_in,
    output track_stage_t stage_out
);

    track_stage_t stage_p [DEPTH];

    // Stage 0 captures the new request; later stages shift; reset drops all in-flight entries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) stage_p[i] <= '0;
        end else begin
            stage_p[0] <= stage_in;
            for (int i = 1; i < DEPTH; i++) stage_p[i] <= stage_p[i-1];
        end
    end

    assign stage_out = stage_p[DEPTH-1];

endmodule

// File: rtl/merge_memory_banked.sv
// Presents NUM_BANKS single-port SRAM macros as one linear memory. The upper
// address bits pick the bank; only that bank is chip-selected. A tracking
// pipeline of READ_LATENCY stages steers the read-data mux and flags.
module merge_memory_banked
    import merge_memory_pkg::*;
#(
    parameter int NUM_BANKS       = 2,
    parameter int BANK_ADDR_WIDTH = 9,
    parameter int DATA_WIDTH      = 32,
    parameter int READ_LATENCY    = 1,
    parameter int ADDR_WIDTH      = BANK_ADDR_WIDTH + bank_idx_w(NUM_BANKS)
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      req_i,
    input  logic                                      we_i,
    input  logic [ADDR_WIDTH-1:0]                     addr_i,
    input  logic [DATA_WIDTH-1:0]                     wdata_i,
    input  logic [DATA_WIDTH/8-1:0]                   wmask_i,
    output logic [DATA_WIDTH-1:0]                     rdata_o,
    output logic                                      rvalid_o,
    output logic                                      err_o,
    output logic [NUM_BANKS-1:0]                      csb_mem_o,
    output logic [NUM_BANKS-1:0]                      web_mem_o,
    output logic [NUM_BANKS-1:0][BANK_ADDR_WIDTH-1:0] addr_mem_o,
    output logic [DATA_WIDTH-1:0]                     wdata_mem_o,
    output logic [DATA_WIDTH/8-1:0]                   wmask_mem_o,
    input  logic [NUM_BANKS-1:0][DATA_WIDTH-1:0]      dout_mem_i
);

    localparam int SEL_W = bank_idx_w(NUM_BANKS);

    logic [SEL_W-1:0] sel;
    logic             oor;
    track_stage_t     stage_in;
    track_stage_t     stage_out;

    assign sel = addr_i[ADDR_WIDTH-1:BANK_ADDR_WIDTH];

    // With a power-of-two bank count every select value maps to a real bank.
    generate
        if ((1 << SEL_W) == NUM_BANKS) begin : g_full_range
            assign oor = 1'b0;
        end else begin : g_partial_range
            assign oor = (32'(sel) >= 32'(NUM_BANKS));
        end
    endgenerate

    // Macro side: select only the addressed bank; address/data/mask are broadcast.
    always_comb begin
        csb_mem_o  = '1;
        web_mem_o  = '1;
        addr_mem_o = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            csb_mem_o[b]  = ~(req_i & ~oor & (sel == SEL_W'(b)));
            web_mem_o[b]  = ~(req_i & ~oor & we_i & (sel == SEL_W'(b)));
            addr_mem_o[b] = addr_i[BANK_ADDR_WIDTH-1:0];
        end
    end

    assign wdata_mem_o = wdata_i;
    assign wmask_mem_o = wmask_i;

    assign stage_in.vld  = req_i;
    assign stage_in.rd   = ~we_i;
    assign stage_in.oor  = oor;
    assign stage_in.bank = MAX_BANK_W'(sel);

    merge_memory_track_pipe #(
        .DEPTH(READ_LATENCY)
    ) u_track_pipe (
        .clk      (clk),
        .rst      (rst),
        .stage_in (stage_in),
        .stage_out(stage_out)
    );

    // Response side: flags from the last tracking stage, data muxed from its bank.
    always_comb begin
        rvalid_o = stage_out.vld & stage_out.rd & ~stage_out.oor;
        err_o    = stage_out.vld & stage_out.oor;
        rdata_o  = '0;
        if (rvalid_o) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (stage_out.bank == MAX_BANK_W'(b)) rdata_o = dout_mem_i[b];
            end
        end
    end

endmodule

// File: tb/tb_merge_memory_banked.sv
// Directed bench for the banked SRAM merger: three instances (3 banks / latency 1,
// 3 banks / latency 2, 2 banks / latency 1) each driving behavioural macro models.
module tb_merge_memory_banked;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        we;
    logic [10:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        req_a, req_b, req_c;

    // Instance A: 3 banks, latency 1
    logic [31:0]      rdata_a;
    logic             rvalid_a, err_a;
    logic [2:0]       csb_a, web_a;
    logic [2:0][8:0]  amem_a;
    logic [31:0]      wdm_a;
    logic [3:0]       wmm_a;
    logic [2:0][31:0] dout_a;

    // Instance B: 3 banks, latency 2
    logic [31:0]      rdata_b;
    logic             rvalid_b, err_b;
    logic [2:0]       csb_b, web_b;
    logic [2:0][8:0]  amem_b;
    logic [31:0]      wdm_b;
    logic [3:0]       wmm_b;
    logic [2:0][31:0] dout_b1, dout_b;

    // Instance C: 2 banks, latency 1
    logic [31:0]      rdata_c;
    logic             rvalid_c, err_c;
    logic [1:0]       csb_c, web_c;
    logic [1:0][8:0]  amem_c;
    logic [31:0]      wdm_c;
    logic [3:0]       wmm_c;
    logic [1:0][31:0] dout_c;

    merge_memory_banked #(.NUM_BANKS(3), .BANK_ADDR_WIDTH(9), .DATA_WIDTH(32), .READ_LATENCY(1)) dut_a (
        .clk(clk), .rst(rst), .req_i(req_a), .we_i(we), .addr_i(addr), .wdata_i(wdata),
        .wmask_i(wmask), .rdata_o(rdata_a), .rvalid_o(rvalid_a), .err_o(err_a),
        .csb_mem_o(csb_a), .web_mem_o(web_a), .addr_mem_o(amem_a), .wdata_mem_o(wdm_a),
        .wmask_mem_o(wmm_a), .dout_mem_i(dout_a));

    merge_memory_banked #(.NUM_BANKS(3), .BANK_ADDR_WIDTH(9), .DATA_WIDTH(32), .READ_LATENCY(2)) dut_b (
        .clk(clk), .rst(rst), .req_i(req_b), .we_i(we), .addr_i(addr), .wdata_i(wdata),
        .wmask_i(wmask), .rdata_o(rdata_b), .rvalid_o(rvalid_b), .err_o(err_b),
        .csb_mem_o(csb_b), .web_mem_o(web_b), .addr_mem_o(amem_b), .wdata_mem_o(wdm_b),
        .wmask_mem_o(wmm_b), .dout_mem_i(dout_b));

    merge_memory_banked #(.NUM_BANKS(2), .BANK_ADDR_WIDTH(9), .DATA_WIDTH(32), .READ_LATENCY(1)) dut_c (
        .clk(clk), .rst(rst), .req_i(req_c), .we_i(we), .addr_i(addr[9:0]), .wdata_i(wdata),
        .wmask_i(wmask), .rdata_o(rdata_c), .rvalid_o(rvalid_c), .err_o(err_c),
        .csb_mem_o(csb_c), .web_mem_o(web_c), .addr_mem_o(amem_c), .wdata_mem_o(wdm_c),
        .wmask_mem_o(wmm_c), .dout_mem_i(dout_c));

    // Behavioural single-port macros
    logic [31:0] mem_a [3][512];
    logic [31:0] mem_b [3][512];
    logic [31:0] mem_c [2][512];

    always @(posedge clk) begin
        for (int b = 0; b < 3; b++) begin
            if (!csb_a[b]) begin
                if (!web_a[b]) begin
                    for (int k = 0; k < 4; k++)
                        if (wmm_a[k]) mem_a[b][amem_a[b]][8*k +: 8] <= wdm_a[8*k +: 8];
                end else begin
                    dout_a[b] <= mem_a[b][amem_a[b]];
                end
            end
        end
    end

    always @(posedge clk) begin
        for (int b = 0; b < 3; b++) begin
            if (!csb_b[b]) begin
                if (!web_b[b]) begin
                    for (int k = 0; k < 4; k++)
                        if (wmm_b[k]) mem_b[b][amem_b[b]][8*k +: 8] <= wdm_b[8*k +: 8];
                end else begin
                    dout_b1[b] <= mem_b[b][amem_b[b]];
                end
            end
        end
        dout_b <= dout_b1;
    end

    always @(posedge clk) begin
        for (int b = 0; b < 2; b++) begin
            if (!csb_c[b]) begin
                if (!web_c[b]) begin
                    for (int k = 0; k < 4; k++)
                        if (wmm_c[k]) mem_c[b][amem_c[b]][8*k +: 8] <= wdm_c[8*k +: 8];
                end else begin
                    dout_c[b] <= mem_c[b][amem_c[b]];
                end
            end
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_bus(input logic w, input logic [10:0] a, input logic [31:0] d, input logic [3:0] m);
        we    = w;
        addr  = a;
        wdata = d;
        wmask = m;
    endtask

    logic [31:0] ref_c [1024];

    initial begin
        logic [9:0]  ra;
        logic        rw, rq, exp_rd, err_seen;
        logic [31:0] rd, exp_data;
        logic [3:0]  rm;

        req_a = 0; req_b = 0; req_c = 0;
        set_bus(0, 11'h0, 32'h0, 4'h0);
        err_seen = 0;

        // Reset state
        tick(); tick();
        check("rst_rvalid_a", rvalid_a, 1'b0);
        check("rst_err_a", err_a, 1'b0);
        check("rst_rdata_a", rdata_a, 32'h0);
        check("rst_rvalid_b", rvalid_b, 1'b0);
        set_bus(0, 11'h405, 32'h0, 4'h0);
        req_a = 1;
        #1;
        check("rst_csb_follow", csb_a, 3'b011);
        req_a = 0;
        rst = 0;
        tick();

        // Preload one word per bank on A
        req_a = 1;
        set_bus(1, 11'h000, 32'hA0A0A0A0, 4'hF); tick();
        set_bus(1, 11'h200, 32'hB1B1B1B1, 4'hF); tick();
        set_bus(1, 11'h400, 32'hC2C2C2C2, 4'hF); tick();

        // In-range write
        set_bus(1, 11'h405, 32'hDEADBEEF, 4'hF);
        #1;
        check("wr_csb", csb_a, 3'b011);
        check("wr_web", web_a, 3'b011);
        check("wr_addr2", amem_a[2], 9'd5);
        check("wr_addr0", amem_a[0], 9'd5);
        tick();
        req_a = 0;
        check("wr_rvalid", rvalid_a, 1'b0);
        check("wr_err", err_a, 1'b0);

        // Read back
        set_bus(0, 11'h405, 32'h0, 4'h0);
        req_a = 1;
        #1;
        check("rd_csb", csb_a, 3'b011);
        check("rd_web", web_a, 3'b111);
        tick();
        req_a = 0;
        check("rd_rvalid", rvalid_a, 1'b1);
        check("rd_data", rdata_a, 32'hDEADBEEF);

        // Back-to-back reads across banks
        set_bus(0, 11'h000, 32'h0, 4'h0); req_a = 1; tick();
        set_bus(0, 11'h200, 32'h0, 4'h0);
        check("b2b0_vld", rvalid_a, 1'b1);
        check("b2b0_data", rdata_a, 32'hA0A0A0A0);
        tick();
        set_bus(0, 11'h400, 32'h0, 4'h0);
        check("b2b1_vld", rvalid_a, 1'b1);
        check("b2b1_data", rdata_a, 32'hB1B1B1B1);
        tick();
        req_a = 0;
        check("b2b2_vld", rvalid_a, 1'b1);
        check("b2b2_data", rdata_a, 32'hC2C2C2C2);
        tick();
        check("b2b_end_vld", rvalid_a, 1'b0);

        // Out-of-range read and write
        set_bus(0, 11'h605, 32'h0, 4'h0);
        req_a = 1;
        #1;
        check("oor_csb", csb_a, 3'b111);
        check("oor_web", web_a, 3'b111);
        tick();
        req_a = 0;
        check("oor_err", err_a, 1'b1);
        check("oor_rvalid", rvalid_a, 1'b0);
        check("oor_rdata", rdata_a, 32'h0);
        tick();
        check("oor_err_pulse", err_a, 1'b0);
        set_bus(1, 11'h7FF, 32'h12345678, 4'hF);
        req_a = 1;
        tick();
        req_a = 0;
        check("oorw_err", err_a, 1'b1);
        check("oorw_rvalid", rvalid_a, 1'b0);

        // Masked write followed immediately by a read of the same word
        set_bus(1, 11'h405, 32'h000000AA, 4'b0001);
        req_a = 1;
        tick();
        set_bus(0, 11'h405, 32'h0, 4'h0);
        tick();
        req_a = 0;
        check("raw_vld", rvalid_a, 1'b1);
        check("raw_data", rdata_a, 32'hDEADBEAA);

        // Instance C: fill all 1024 words, then random traffic against a model
        req_c = 1;
        for (int i = 0; i < 1024; i++) begin
            ref_c[i] = $urandom;
            set_bus(1, 11'(i), ref_c[i], 4'hF);
            tick();
            if (err_c) err_seen = 1;
        end
        check("fill_err", err_seen, 1'b0);
        for (int i = 0; i < 400; i++) begin
            ra = 10'($urandom_range(0, 1023));
            rw = 1'($urandom_range(0, 1));
            rq = ($urandom_range(0, 4) != 0);
            rd = $urandom;
            rm = 4'($urandom_range(0, 15));
            set_bus(rw, {1'b0, ra}, rd, rm);
            req_c    = rq;
            exp_rd   = rq & ~rw;
            exp_data = ref_c[ra];
            if (rq && rw)
                for (int k = 0; k < 4; k++)
                    if (rm[k]) ref_c[ra][8*k +: 8] = rd[8*k +: 8];
            tick();
            check("rnd_vld", rvalid_c, exp_rd);
            check("rnd_err", err_c, 1'b0);
            if (exp_rd) check("rnd_data", rdata_c, exp_data);
        end
        req_c = 0;
        tick();

        // Instance B: latency 2
        set_bus(1, 11'h203, 32'h5A5A5A5A, 4'hF);
        req_b = 1;
        tick();
        set_bus(0, 11'h203, 32'h0, 4'h0);
        tick();
        req_b = 0;
        check("l2_n_vld", rvalid_b, 1'b0);
        tick();
        check("l2_n1_vld", rvalid_b, 1'b1);
        check("l2_n1_data", rdata_b, 32'h5A5A5A5A);
        tick();
        check("l2_after_vld", rvalid_b, 1'b0);

        set_bus(0, 11'h605, 32'h0, 4'h0);
        req_b = 1;
        tick();
        req_b = 0;
        check("l2_oor_early", err_b, 1'b0);
        tick();
        check("l2_oor_err", err_b, 1'b1);
        tick();

        // Reset while a read is in flight
        set_bus(0, 11'h203, 32'h0, 4'h0);
        req_b = 1;
        tick();
        req_b = 0;
        #2;
        rst = 1;
        #1;
        check("mid_rst_vld", rvalid_b, 1'b0);
        check("mid_rst_err", err_b, 1'b0);
        check("mid_rst_data", rdata_b, 32'h0);
        tick();
        check("mid_rst_n1_vld", rvalid_b, 1'b0);
        rst = 0;
        tick();
        check("post_rst_vld", rvalid_b, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
